fir_filter_tdm_mc: RTL and testbench

- Time-multiplexed, multi-channel FIR filter with one shared multiply-accumulate unit.
- Coefficients are loaded at run time.
- Output stage applies programmable rounding, shifting and saturation.
- Serves low-rate multi-channel paths (e.g. per-antenna decimated streams) where a fully parallel systolic filter per channel is too costly.
- Each channel has its own delay-line history; all channels share one coefficient set.

---
 rtl/fir_filter_tdm_mc.sv | 217 +++++++++++++++++++++
 tb/tb_fir_filter_tdm_mc.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_tdm_mc.sv
// Time-multiplexed multi-channel FIR filter with one shared MAC.
// Per-channel circular histories share one run-time coefficient set.
module fir_filter_tdm_mc #(
   parameter int INPUT_WIDTH  = 16,
   parameter int COEFF_WIDTH  = 8,
   parameter int OUTPUT_WIDTH = 16,
   parameter int NUM_TAPS     = 16,
   parameter int NUM_CHANNELS = 4,
   parameter int SHIFT        = 7,
   parameter int ROUND        = 1,
   parameter int SATURATE     = 1,
   localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
   localparam int TAP_W = $clog2(NUM_TAPS)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           valid_in,
   output logic                           ready_in,
   input  logic [CH_W-1:0]                chan_in,
   input  logic signed [INPUT_WIDTH-1:0]  din,
   input  logic                           coef_we,
   input  logic [TAP_W-1:0]               coef_addr,
   input  logic signed [COEFF_WIDTH-1:0]  coef_data,
   output logic                           valid_out,
   output logic [CH_W-1:0]                chan_out,
   output logic signed [OUTPUT_WIDTH-1:0] dout,
   output logic                           overflow
);

   localparam int PW    = INPUT_WIDTH + COEFF_WIDTH;
   localparam int ACC_W = PW + TAP_W;
   localparam int DEPTH = NUM_CHANNELS * NUM_TAPS;
   localparam int HA_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OW    = OUTPUT_WIDTH;

   localparam logic signed [ACC_W:0] RND_C =
      (ROUND != 0 && SHIFT > 0) ?
      ((ACC_W+1)'(1) <<< (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;
   localparam logic signed [ACC_W:0] MAXV =
      {{(ACC_W+2-OW){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [ACC_W:0] MINV =
      {{(ACC_W+2-OW){1'b1}}, {(OW-1){1'b0}}};
   localparam logic [OW-1:0] OMAX = {1'b0, {(OW-1){1'b1}}};
   localparam logic [OW-1:0] OMIN = {1'b1, {(OW-1){1'b0}}};

   typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_MAC, S_OUT} state_t;

   state_t r_state;
   state_t w_next;

   logic signed [COEFF_WIDTH-1:0] r_coef [NUM_TAPS];
   logic [TAP_W-1:0]              r_ptr  [NUM_CHANNELS];
   logic signed [INPUT_WIDTH-1:0] r_hist [DEPTH];
   logic [CH_W-1:0]               r_ch;
   logic [TAP_W-1:0]              r_base;
   logic [TAP_W-1:0]              r_tap;
   logic signed [ACC_W-1:0]       r_acc;
   logic [CH_W-1:0]               r_clr_ch;
   logic [TAP_W-1:0]              r_clr_tap;
   logic                          r_valid;
   logic [CH_W-1:0]               r_chan_out;
   logic [OW-1:0]                 r_dout;
   logic                          r_ovf;

   logic                    w_ready;
   logic                    w_coef_en;
   logic                    w_clr;
   logic                    w_mac;
   logic                    w_out;
   logic                    w_chan_ok;
   logic                    w_accept;
   logic                    w_clr_last;
   logic                    w_tap_last;
   logic [TAP_W:0]          w_diff;
   logic [TAP_W-1:0]        w_idx;
   logic [TAP_W-1:0]        w_ptr_nxt;
   logic [HA_W-1:0]         w_rd_addr;
   logic [HA_W-1:0]         w_wr_addr;
   logic [HA_W-1:0]         w_clr_addr;
   logic signed [PW-1:0]    w_prod;
   logic signed [ACC_W-1:0] w_prod_x;
   logic signed [ACC_W:0]   w_rnd;
   logic signed [ACC_W:0]   w_shf;
   logic                    w_hi;
   logic                    w_lo;
   logic [OW-1:0]           w_dout;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_CLEAR;
      else     r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_CLEAR: if (w_clr_last) w_next = S_IDLE;
         S_IDLE:  if (w_accept)   w_next = S_MAC;
         S_MAC:   if (w_tap_last) w_next = S_OUT;
         S_OUT:   w_next = S_IDLE;
         default: w_next = S_CLEAR;
      endcase
   end

   // State-decoded control strobes
   always_comb begin
      w_ready   = 1'b0;
      w_coef_en = 1'b0;
      w_clr     = 1'b0;
      w_mac     = 1'b0;
      w_out     = 1'b0;
      unique case (r_state)
         S_CLEAR: begin w_clr = 1'b1; w_coef_en = 1'b1; end
         S_IDLE:  begin w_ready = 1'b1; w_coef_en = 1'b1; end
         S_MAC:   w_mac = 1'b1;
         S_OUT:   w_out = 1'b1;
         default: w_clr = 1'b1;
      endcase
   end

   assign w_chan_ok  = int'(chan_in) < NUM_CHANNELS;
   assign w_accept   = w_ready && valid_in && w_chan_ok;
   assign w_clr_last = (r_clr_ch == CH_W'(NUM_CHANNELS - 1)) &&
                       (r_clr_tap == TAP_W'(NUM_TAPS - 1));
   assign w_tap_last = r_tap == TAP_W'(NUM_TAPS - 1);

   assign w_ptr_nxt = (r_ptr[chan_in] == TAP_W'(NUM_TAPS - 1)) ?
                      '0 : r_ptr[chan_in] + TAP_W'(1);

   // Tap k reads the sample k steps older than the newest, modulo NUM_TAPS
   assign w_diff = {1'b0, r_base} - {1'b0, r_tap};
   assign w_idx  = w_diff[TAP_W] ?
                   w_diff[TAP_W-1:0] + TAP_W'(NUM_TAPS) :
                   w_diff[TAP_W-1:0];

   assign w_rd_addr  = HA_W'(int'(r_ch) * NUM_TAPS + int'(w_idx));
   assign w_wr_addr  = HA_W'(int'(chan_in) * NUM_TAPS +
                             int'(r_ptr[chan_in]));
   assign w_clr_addr = HA_W'(int'(r_clr_ch) * NUM_TAPS +
                             int'(r_clr_tap));

   assign w_prod   = r_coef[r_tap] * r_hist[w_rd_addr];
   assign w_prod_x = {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};

   assign w_rnd  = {r_acc[ACC_W-1], r_acc} + RND_C;
   assign w_shf  = w_rnd >>> SHIFT;
   assign w_hi   = w_shf > MAXV;
   assign w_lo   = w_shf < MINV;
   assign w_dout = (SATURATE != 0 && w_hi) ? OMAX :
                   (SATURATE != 0 && w_lo) ? OMIN :
                   w_shf[OW-1:0];

   // Coefficients, pointers, clear sweep and the MAC accumulator
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_TAPS; i++) r_coef[i] <= '0;
         for (int i = 0; i < NUM_CHANNELS; i++) r_ptr[i] <= '0;
         r_ch      <= '0;
         r_base    <= '0;
         r_tap     <= '0;
         r_acc     <= '0;
         r_clr_ch  <= '0;
         r_clr_tap <= '0;
      end else begin
         if (w_coef_en && coef_we) r_coef[coef_addr] <= coef_data;
         if (w_clr) begin
            if (r_clr_tap == TAP_W'(NUM_TAPS - 1)) begin
               r_clr_tap <= '0;
               r_clr_ch  <= w_clr_last ? '0 : r_clr_ch + CH_W'(1);
            end else begin
               r_clr_tap <= r_clr_tap + TAP_W'(1);
            end
         end
         if (w_accept) begin
            r_ptr[chan_in] <= w_ptr_nxt;
            r_ch           <= chan_in;
            r_base         <= r_ptr[chan_in];
            r_tap          <= '0;
         end
         if (w_mac) begin
            r_acc <= (r_tap == '0) ? w_prod_x : r_acc + w_prod_x;
            r_tap <= r_tap + TAP_W'(1);
         end
      end
   end

   // History memory: zeroed by the clear sweep, written on accept
   always_ff @(posedge clk) begin
      if (w_clr)         r_hist[w_clr_addr] <= '0;
      else if (w_accept) r_hist[w_wr_addr]  <= din;
   end

   // Output registers, updated only in the OUT state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_chan_out <= '0;
         r_dout     <= '0;
         r_ovf      <= 1'b0;
      end else begin
         r_valid <= w_out;
         if (w_out) begin
            r_chan_out <= r_ch;
            r_dout     <= w_dout;
            r_ovf      <= w_hi | w_lo;
         end
      end
   end

   assign ready_in  = w_ready;
   assign valid_out = r_valid;
   assign chan_out  = r_chan_out;
   assign dout      = r_dout;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_fir_filter_tdm_mc.sv
// Directed and randomized bench for fir_filter_tdm_mc.
// Expected outputs come from a plain convolution model.
module tb_fir_filter_tdm_mc;

   localparam int NUM_TAPS = 16;
   localparam int NUM_CH   = 4;
   localparam int SHIFT    = 7;
   localparam int ROUND    = 1;
   localparam int SATURATE = 1;
   localparam longint OMAX = 32767;
   localparam longint OMIN = -32768;

   logic               clk = 1'b0;
   logic               rst;
   logic               valid_in;
   logic               ready_in;
   logic [1:0]         chan_in;
   logic signed [15:0] din;
   logic               coef_we;
   logic [3:0]         coef_addr;
   logic signed [7:0]  coef_data;
   logic               valid_out;
   logic [1:0]         chan_out;
   logic signed [15:0] dout;
   logic               overflow;

   int n_tests = 0;
   int n_fail  = 0;

   int cm [NUM_TAPS];
   int hm [NUM_CH][NUM_TAPS];

   fir_filter_tdm_mc dut (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_in),
      .ready_in  (ready_in),
      .chan_in   (chan_in),
      .din       (din),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .valid_out (valid_out),
      .chan_out  (chan_out),
      .dout      (dout),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag,
                      input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // y = sum c[k]*x[n-k], then round-half-up, shift, saturate
   function automatic void model_push(input int ch, input int d,
                                      output longint y, output bit ov);
      longint acc;
      longint q;
      for (int k = NUM_TAPS - 1; k > 0; k--) hm[ch][k] = hm[ch][k-1];
      hm[ch][0] = d;
      acc = 0;
      for (int k = 0; k < NUM_TAPS; k++)
         acc += longint'(cm[k]) * longint'(hm[ch][k]);
      if (ROUND != 0 && SHIFT > 0) acc += longint'(1) << (SHIFT - 1);
      q  = acc >>> SHIFT;
      ov = (q > OMAX) || (q < OMIN);
      if (SATURATE != 0 && q > OMAX) y = OMAX;
      else if (SATURATE != 0 && q < OMIN) y = OMIN;
      else y = longint'(signed'(q[15:0]));
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < NUM_TAPS; k++) cm[k] = 0;
      for (int c = 0; c < NUM_CH; c++)
         for (int k = 0; k < NUM_TAPS; k++) hm[c][k] = 0;
   endfunction

   // Called #1 after the accepting edge; that edge counts as edge 1
   task automatic watch(input string tag, input longint ey,
                        input int ech, input bit eov, input bit mcw);
      int lat;
      bit got;
      lat = 1;
      got = 0;
      while (!got && lat < 60) begin
         if (mcw && lat == 3) begin
            coef_we   = 1'b1;
            coef_addr = 4'($urandom);
            coef_data = 8'($urandom);
         end else begin
            coef_we = 1'b0;
         end
         @(posedge clk);
         #1;
         lat++;
         if (valid_out === 1'b1) got = 1;
      end
      coef_we = 1'b0;
      chk({tag, ".lat"}, lat, NUM_TAPS + 2);
      chk({tag, ".dout"}, dout, ey);
      chk({tag, ".chan"}, chan_out, ech);
      chk({tag, ".ovf"}, overflow, eov);
      chk({tag, ".rdy"}, ready_in, 1);
      @(posedge clk);
      #1;
      chk({tag, ".pulse"}, valid_out, 0);
      chk({tag, ".hold"}, dout, ey);
   endtask

   task automatic wait_ready(input string tag);
      int w;
      w = 0;
      @(negedge clk);
      while (ready_in !== 1'b1 && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk({tag, ".ready"}, ready_in, 1);
   endtask

   task automatic send(input string tag, input int ch, input int d,
                       input bit acw, input int aa, input int ad,
                       input bit mcw);
      longint ey;
      bit eov;
      wait_ready(tag);
      valid_in = 1'b1;
      chan_in  = 2'(ch);
      din      = 16'(d);
      if (acw) begin
         coef_we   = 1'b1;
         coef_addr = 4'(aa);
         coef_data = 8'(ad);
      end
      @(posedge clk);
      if (acw) cm[aa] = ad;
      model_push(ch, d, ey, eov);
      #1;
      valid_in = 1'b0;
      coef_we  = 1'b0;
      watch(tag, ey, ch, eov, mcw);
   endtask

   task automatic wcoef(input int a, input int v);
      @(negedge clk);
      coef_we   = 1'b1;
      coef_addr = 4'(a);
      coef_data = 8'(v);
      @(negedge clk);
      coef_we = 1'b0;
      cm[a]   = v;
   endtask

   function automatic int rnd_s16();
      return int'($urandom_range(65535)) - 32768;
   endfunction

   initial begin
      int cnt;
      bit vseen;
      longint ey;
      bit eov;

      rst       = 1'b1;
      valid_in  = 1'b0;
      chan_in   = '0;
      din       = '0;
      coef_we   = 1'b0;
      coef_addr = '0;
      coef_data = '0;
      model_reset();

      repeat (3) @(negedge clk);
      chk("rst.ready", ready_in, 0);
      chk("rst.valid", valid_out, 0);
      chk("rst.dout", dout, 0);
      chk("rst.chan", chan_out, 0);
      chk("rst.ovf", overflow, 0);

      // Clear sweep with valid_in held; a coef write lands mid-sweep
      valid_in = 1'b1;
      chan_in  = 2'd3;
      din      = 16'sd100;
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      while (ready_in !== 1'b1 && cnt < 200) begin
         @(posedge clk);
         #1;
         cnt++;
         if (cnt == 10) begin
            coef_we   = 1'b1;
            coef_addr = 4'd0;
            coef_data = 8'sd5;
         end else begin
            coef_we = 1'b0;
         end
      end
      coef_we = 1'b0;
      chk("clr.len", cnt, NUM_CH * NUM_TAPS);
      cm[0] = 5;
      @(posedge clk);
      model_push(3, 100, ey, eov);
      #1;
      valid_in = 1'b0;
      watch("first", ey, 3, eov, 1'b0);

      // Impulse on channel 0
      wcoef(0, 64);
      wcoef(1, 32);
      send("imp0", 0, 256, 0, 0, 0, 0);
      send("imp1", 0, 0, 0, 0, 0, 0);
      send("imp2", 0, 0, 0, 0, 0, 0);
      send("imp3", 0, 0, 0, 0, 0, 0);

      // Channel isolation
      send("iso0", 1, 256, 0, 0, 0, 0);
      send("iso1", 2, 0, 0, 0, 0, 0);
      send("iso2", 1, 0, 0, 0, 0, 0);

      // Saturation both ways
      wcoef(0, 127);
      wcoef(1, 127);
      send("satp0", 0, 32767, 0, 0, 0, 0);
      send("satp1", 0, 32767, 0, 0, 0, 0);
      send("satn0", 0, -32768, 0, 0, 0, 0);
      send("satn1", 0, -32768, 0, 0, 0, 0);

      // Rounding around the half-LSB point
      wcoef(0, 1);
      wcoef(1, 0);
      send("rnd64", 3, 64, 0, 0, 0, 0);
      send("rnd63", 2, 63, 0, 0, 0, 0);
      send("rndm64", 1, -64, 0, 0, 0, 0);
      send("rndm65", 0, -65, 0, 0, 0, 0);

      // Coefficient write on the accept edge must reach that MAC
      send("acw", 2, 1000, 1, 0, -7, 0);

      // Random coefficients and samples, with ignored MAC-time writes
      for (int i = 0; i < NUM_TAPS; i++)
         wcoef(i, int'($urandom_range(255)) - 128);
      for (int i = 0; i < 24; i++)
         send("rand", int'($urandom_range(NUM_CH - 1)), rnd_s16(),
              (i % 3) == 0, int'($urandom_range(NUM_TAPS - 1)),
              int'($urandom_range(255)) - 128, (i % 2) == 0);

      // Reset during MAC cycle 5
      wait_ready("rmac");
      valid_in = 1'b1;
      chan_in  = 2'd0;
      din      = 16'sd256;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rmac.ready", ready_in, 0);
      chk("rmac.valid", valid_out, 0);
      chk("rmac.dout", dout, 0);
      chk("rmac.ovf", overflow, 0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst   = 1'b0;
      cnt   = 0;
      vseen = 0;
      while (ready_in !== 1'b1 && cnt < 200) begin
         @(posedge clk);
         #1;
         cnt++;
         if (valid_out === 1'b1) vseen = 1;
      end
      chk("rmac.clr", cnt, NUM_CH * NUM_TAPS);
      chk("rmac.nov", vseen, 0);
      send("post0", 0, 256, 0, 0, 0, 0);
      send("post1", 1, -3000, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
